// File: rtl/burst_ddr_sram.sv
// Burst SRAM that moves one even/odd word pair per clock.
// Bursts wrap inside their BURST_LEN-aligned window. Read data is registered and
// qualified by o_read_valid. Storage is not reset, so its contents survive a reset.
module burst_ddr_sram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [2*DATA_WIDTH-1:0] i_write_data,
    output logic                    o_ready,
    output logic [2*DATA_WIDTH-1:0] o_read_data,
    output logic                    o_read_valid,
    output logic                    o_cmd_error
);

    localparam int unsigned Pairs = BURST_LEN / 2;
    localparam int unsigned PairW = (Pairs > 1) ? $clog2(Pairs) : 1;
    localparam int unsigned Words = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OffMask  = ADDR_WIDTH'(BURST_LEN - 1);
    localparam logic [PairW-1:0]      LastPair = PairW'(Pairs - 1);

    if ((BURST_LEN < 2) || (BURST_LEN > Words) || ((BURST_LEN & (BURST_LEN - 1)) != 0))
    begin : g_bad_burst_len
        $error("burst_ddr_sram: BURST_LEN must be a power of two in [2, 2**ADDR_WIDTH]");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWburst,
        StRburst
    } state_e;

    state_e                  r_state;
    logic [PairW-1:0]        r_pair;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [2*DATA_WIDTH-1:0] r_read_data;
    logic                    r_read_valid;
    logic                    r_cmd_error;
    logic [DATA_WIDTH-1:0]   r_mem [Words];

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_last;
    logic                  w_mem_we;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_start_base;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [PairW-1:0]      w_pair;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_even_addr;
    logic [ADDR_WIDTH-1:0] w_odd_addr;
    logic                  w_unused_addr0;

    assign w_idle         = (r_state == StIdle);
    assign w_accept       = i_enable & w_idle & (i_read ^ i_write);
    assign w_illegal      = i_enable & w_idle & i_read & i_write;
    assign w_last         = (r_pair == LastPair);
    assign w_start_base   = {i_address[ADDR_WIDTH-1:1], 1'b0};
    assign w_unused_addr0 = i_address[0];

    // Pair 0 is handled on the accept edge straight from the inputs; later pairs
    // come from the registered base and pair index.
    assign w_base      = w_idle ? w_start_base : r_base;
    assign w_pair      = w_idle ? '0 : r_pair;
    assign w_step      = ADDR_WIDTH'({w_pair, 1'b0});
    assign w_even_addr = (w_base & ~OffMask) | ((w_base + w_step) & OffMask);
    assign w_odd_addr  = w_even_addr | ADDR_WIDTH'(1);

    // Gating on reset stops a clock edge during reset from writing a stray pair.
    assign w_mem_we = i_rst_n & ((w_accept & i_write) | (r_state == StWburst));
    assign w_rd_en  = (w_accept & i_read) | (r_state == StRburst);

    assign o_ready      = w_idle;
    assign o_read_data  = r_read_data;
    assign o_read_valid = r_read_valid;
    assign o_cmd_error  = r_cmd_error;

    // Command FSM, pair counter and registered read/error outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_pair       <= '0;
            r_base       <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_cmd_error  <= w_illegal;
            r_read_valid <= w_rd_en;
            if (w_rd_en) begin
                r_read_data <= {r_mem[w_odd_addr], r_mem[w_even_addr]};
            end
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_base <= w_start_base;
                        if (Pairs > 1) begin
                            r_pair  <= PairW'(1);
                            r_state <= i_write ? StWburst : StRburst;
                        end
                    end
                end
                StWburst, StRburst: begin
                    if (w_last) begin
                        r_pair  <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_pair <= r_pair + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Storage array; both words of a pair are written on the same edge.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_even_addr] <= i_write_data[DATA_WIDTH-1:0];
            r_mem[w_odd_addr]  <= i_write_data[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule
